// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between fetch (I) and load/store (D)
// D wins memory conflicts; after MAXDRUN back-to-back D wins with fetch waiting, fetch is forced once.
module mem_port_arbiter #(
  parameter int DBITS   = 16,
  parameter int ABITS   = 12,
  parameter int MAXDRUN = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IREQ,
  input  logic [DBITS-1:0] IADDR,
  output logic             IGNT,
  output logic             IRVALID,
  output logic [DBITS-1:0] IRDATA,
  input  logic             DREQ,
  input  logic             DWE,
  input  logic [DBITS-1:0] DADDR,
  input  logic [DBITS-1:0] DWDATA,
  output logic             DGNT,
  output logic             DRVALID,
  output logic [DBITS-1:0] DRDATA,
  output logic [ABITS-1:0] MADDR,
  output logic             MWE,
  output logic [DBITS-1:0] MDIN,
  input  logic [DBITS-1:0] MDOUT,
  output logic [DBITS-1:0] IOADDR,
  output logic             IOWE,
  output logic [DBITS-1:0] IOWDATA,
  input  logic [DBITS-1:0] IORDATA,
  output logic             ISTALL
);

  localparam int DRW = $clog2(MAXDRUN + 1);

  typedef enum logic {NORMAL = 1'b0, FAIR = 1'b1} mode_t;

  mode_t            r_mode;
  mode_t            w_mode_nxt;
  logic [DRW-1:0]   r_drun;
  logic [DRW-1:0]   w_drun_nxt;
  logic [DRW-1:0]   w_drun_inc;
  logic             r_ipend;
  logic             r_dpend;
  logic             r_dsrc;
  logic [DBITS-1:0] r_io_q;
  logic [ABITS-1:0] r_maddr;

  logic             w_d_io;
  logic             w_conflict;
  logic             w_ignt;
  logic             w_dgnt;
  logic             w_d_mem_gnt;
  logic [ABITS-1:0] w_maddr;
  logic             w_unused;

  assign w_d_io      = |DADDR[DBITS-1:DBITS-3];
  assign w_conflict  = IREQ & DREQ & ~w_d_io;
  assign w_d_mem_gnt = w_dgnt & ~w_d_io;
  assign w_drun_inc  = r_drun + DRW'(1);
  assign w_unused    = ^{IADDR[0], IADDR[DBITS-1:ABITS+1], DADDR[0]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mode  <= NORMAL;
      r_drun  <= '0;
      r_ipend <= 1'b0;
      r_dpend <= 1'b0;
      r_dsrc  <= 1'b0;
      r_io_q  <= '0;
      r_maddr <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_drun  <= w_drun_nxt;
      r_ipend <= w_ignt;
      r_dpend <= w_dgnt & ~DWE;
      r_maddr <= w_maddr;
      if (w_dgnt) r_dsrc <= w_d_io;
      if (w_dgnt & w_d_io & ~DWE) r_io_q <= IORDATA;
    end
  end

  // Starvation count only advances while fetch is actually being held off by a D memory win.
  always_comb begin
    w_mode_nxt = r_mode;
    w_drun_nxt = r_drun;
    if (w_ignt || !IREQ) begin
      w_drun_nxt = '0;
    end else if (w_d_mem_gnt) begin
      w_drun_nxt = w_drun_inc;
    end
    if (w_ignt) begin
      w_mode_nxt = NORMAL;
    end else if (w_conflict && w_dgnt && (w_drun_inc == DRW'(MAXDRUN))) begin
      w_mode_nxt = FAIR;
    end
  end

  always_comb begin
    w_ignt = 1'b0;
    w_dgnt = 1'b0;
    if (RESET_N) begin
      if (w_conflict) begin
        if (r_mode == FAIR) w_ignt = 1'b1;
        else                w_dgnt = 1'b1;
      end else begin
        w_ignt = IREQ;
        w_dgnt = DREQ;
      end
    end
  end

  // The memory registers its address, so MADDR must be live in the grant cycle.
  always_comb begin
    w_maddr = r_maddr;
    if (w_ignt)           w_maddr = IADDR[ABITS:1];
    else if (w_d_mem_gnt) w_maddr = DADDR[ABITS:1];
  end

  assign IGNT    = w_ignt;
  assign DGNT    = w_dgnt;
  assign ISTALL  = RESET_N & IREQ & ~w_ignt;
  assign MADDR   = w_maddr;
  assign MWE     = w_d_mem_gnt & DWE;
  assign MDIN    = DWDATA;
  assign IOADDR  = DADDR;
  assign IOWDATA = DWDATA;
  assign IOWE    = w_dgnt & w_d_io & DWE;
  assign IRVALID = r_ipend;
  assign IRDATA  = r_ipend ? MDOUT : '0;
  assign DRVALID = r_dpend;
  assign DRDATA  = r_dpend ? (r_dsrc ? r_io_q : MDOUT) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Stimulus pushes expected read returns; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        CLK, RESET_N;
  logic        IREQ, IGNT, IRVALID;
  logic [15:0] IADDR, IRDATA;
  logic        DREQ, DWE, DGNT, DRVALID;
  logic [15:0] DADDR, DWDATA, DRDATA;
  logic [11:0] MADDR;
  logic        MWE;
  logic [15:0] MDIN, MDOUT;
  logic [15:0] IOADDR, IOWDATA, IORDATA;
  logic        IOWE, ISTALL;

  mem_port_arbiter #(.DBITS(16), .ABITS(12), .MAXDRUN(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IRVALID(IRVALID), .IRDATA(IRDATA),
    .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DWDATA(DWDATA), .DGNT(DGNT),
    .DRVALID(DRVALID), .DRDATA(DRDATA),
    .MADDR(MADDR), .MWE(MWE), .MDIN(MDIN), .MDOUT(MDOUT),
    .IOADDR(IOADDR), .IOWE(IOWE), .IOWDATA(IOWDATA), .IORDATA(IORDATA),
    .ISTALL(ISTALL)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q_i[$];
  exp_t        q_d[$];
  logic [15:0] mem     [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] r_mdout;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  bit          no_push = 0;

  assign MDOUT = r_mdout;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  always @(posedge CLK) begin
    if (MWE) mem[MADDR] <= MDIN;
    r_mdout <= mem[MADDR];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (IRVALID === 1'b1) begin
      if (q_i.size() == 0) begin
        check("irvalid_unexpected", 32'(IRVALID), 32'd0);
      end else begin
        e = q_i.pop_front();
        check("irdata", 32'(IRDATA), 32'(e.data));
        check("irvalid_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
    if (DRVALID === 1'b1) begin
      if (q_d.size() == 0) begin
        check("drvalid_unexpected", 32'(DRVALID), 32'd0);
      end else begin
        e = q_d.pop_front();
        check("drdata", 32'(DRDATA), 32'(e.data));
        check("drvalid_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; returns on the next rising edge.
  task automatic step(input string name,
                      input logic ireq, input logic [15:0] iaddr,
                      input logic dreq, input logic dwe, input logic [15:0] daddr,
                      input logic [15:0] dwdata, input logic [15:0] iordata,
                      input logic e_ignt, input logic e_dgnt, input int e_maddr,
                      input logic e_mwe, input logic e_iowe);
    logic        d_io;
    logic [11:0] ia;
    logic [11:0] da;
    #1;
    IREQ = ireq; IADDR = iaddr; DREQ = dreq; DWE = dwe;
    DADDR = daddr; DWDATA = dwdata; IORDATA = iordata;
    #1;
    d_io = (daddr[15:13] != 3'b000);
    ia   = iaddr[12:1];
    da   = daddr[12:1];
    check({name, "_ignt"},   32'(IGNT),   32'(e_ignt));
    check({name, "_dgnt"},   32'(DGNT),   32'(e_dgnt));
    check({name, "_istall"}, 32'(ISTALL), 32'(ireq & ~e_ignt));
    check({name, "_maddr"},  32'(MADDR),  32'(e_maddr));
    check({name, "_mwe"},    32'(MWE),    32'(e_mwe));
    check({name, "_iowe"},   32'(IOWE),   32'(e_iowe));
    if (!no_push) begin
      if (e_ignt) q_i.push_back('{data: ref_mem[ia], cyc: cyc_cnt + 1});
      if (e_dgnt && !dwe) q_d.push_back('{data: (d_io ? iordata : ref_mem[da]), cyc: cyc_cnt + 1});
    end
    if (e_dgnt && dwe && !d_io) ref_mem[da] = dwdata;
    @(posedge CLK);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ignt"},    32'(IGNT),    32'd0);
    check({name, "_dgnt"},    32'(DGNT),    32'd0);
    check({name, "_istall"},  32'(ISTALL),  32'd0);
    check({name, "_irvalid"}, 32'(IRVALID), 32'd0);
    check({name, "_drvalid"}, 32'(DRVALID), 32'd0);
    check({name, "_irdata"},  32'(IRDATA),  32'd0);
    check({name, "_drdata"},  32'(DRDATA),  32'd0);
    check({name, "_mwe"},     32'(MWE),     32'd0);
    check({name, "_iowe"},    32'(IOWE),    32'd0);
    check({name, "_maddr"},   32'(MADDR),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'(i) ^ 16'hA500;
      ref_mem[i] = 16'(i) ^ 16'hA500;
    end
    r_mdout = 16'h0000;
    RESET_N = 1'b0;
    IREQ = 1'b1; IADDR = 16'h0200; DREQ = 1'b1; DWE = 1'b1;
    DADDR = 16'hFFF8; DWDATA = 16'h5555; IORDATA = 16'h0000;
    #2;
    check_reset_outputs("rst0");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst1");
    IREQ = 1'b0; DREQ = 1'b0; DWE = 1'b0; DADDR = 16'h0000;
    #1 RESET_N = 1'b1;
    @(posedge CLK);

    // fetch granted, then reset lands while the read is in flight
    no_push = 1;
    step("midrd", 1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 12'h100, 0, 0);
    no_push = 0;
    #1;
    RESET_N = 1'b0; IREQ = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    @(posedge CLK);
    step("afterrst", 1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 12'h100, 0, 0);

    step("ioconc", 1, 16'h0204, 1, 0, 16'hFFF2, 16'h0000, 16'h0155, 1, 1, 12'h102, 0, 0);

    step("iost",   0, 16'h0000, 1, 1, 16'hFFF8, 16'h1234, 16'h0000, 0, 1, 12'h102, 0, 1);
    step("iost_n", 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 12'h102, 0, 0);
    step("mst",    0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF, 16'h0000, 0, 1, 12'h010, 1, 0);
    step("mld",    0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 16'h0000, 0, 1, 12'h010, 0, 0);
    step("oddld",  0, 16'h0000, 1, 0, 16'h0021, 16'h0000, 16'h0000, 0, 1, 12'h010, 0, 0);

    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++)
        step("cfl_d", 1, 16'h0300, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 1, 12'h008, 0, 0);
      step("cfl_i",  1, 16'h0300, 1, 0, 16'h0010, 16'h0000, 16'h0000, 1, 0, 12'h180, 0, 0);
      step("cfl_d2", 1, 16'h0302, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 1, 12'h008, 0, 0);
      step("cfl_i2", 1, 16'h0302, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 12'h181, 0, 0);
      for (int c = 0; c < 10; c++)
        step("idle", 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 12'h181, 0, 0);
    end

    repeat (3) @(posedge CLK);
    #2;
    check("q_i_drained", 32'(q_i.size()), 32'd0);
    check("q_d_drained", 32'(q_d.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
